// File: rtl/axil_reg_file.sv
// AXI-Lite slave register file: NUM_REGS registers, per-register RW/RO mode and reset
// value, byte-strobe writes, all values exported together with per-register write pulses.

module svc_skidbuf #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid_c,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data_c
);

   logic             empty;
   logic [WIDTH-1:0] buf_data;

   // One-entry buffer: passes straight through when empty, captures a beat the consumer refused
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         empty    <= 1'b1;
         buf_data <= '0;
      end else if (!empty) begin
         if (out_ready) empty <= 1'b1;
      end else if (in_valid && !out_ready) begin
         empty    <= 1'b0;
         buf_data <= in_data;
      end
   end

   assign in_ready    = empty;
   assign out_valid_c = !empty || in_valid;
   assign out_data_c  = empty ? in_data : buf_data;

endmodule

module axil_reg_file #(
   parameter int unsigned NUM_REGS        = 8,
   parameter int unsigned AXIL_ADDR_WIDTH = 32,
   parameter int unsigned AXIL_DATA_WIDTH = 32,
   parameter int unsigned AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
   parameter logic [NUM_REGS-1:0]                 REG_RW     = '1,
   parameter logic [NUM_REGS*AXIL_DATA_WIDTH-1:0] RESET_VALS = '0
) (
   input  logic                                 clk,
   input  logic                                 rst_n,

   output logic [NUM_REGS*AXIL_DATA_WIDTH-1:0]  reg_val,
   input  logic [NUM_REGS*AXIL_DATA_WIDTH-1:0]  ro_val,
   output logic [NUM_REGS-1:0]                  wr_pulse,

   input  logic [AXIL_ADDR_WIDTH-1:0]           s_axil_awaddr,
   input  logic                                 s_axil_awvalid,
   output logic                                 s_axil_awready,
   input  logic [AXIL_DATA_WIDTH-1:0]           s_axil_wdata,
   input  logic [AXIL_STRB_WIDTH-1:0]           s_axil_wstrb,
   input  logic                                 s_axil_wvalid,
   output logic                                 s_axil_wready,
   output logic                                 s_axil_bvalid,
   output logic [1:0]                           s_axil_bresp,
   input  logic                                 s_axil_bready,

   input  logic [AXIL_ADDR_WIDTH-1:0]           s_axil_araddr,
   input  logic                                 s_axil_arvalid,
   output logic                                 s_axil_arready,
   output logic                                 s_axil_rvalid,
   output logic [AXIL_DATA_WIDTH-1:0]           s_axil_rdata,
   output logic [1:0]                           s_axil_rresp,
   input  logic                                 s_axil_rready
);

   localparam int unsigned DW     = AXIL_DATA_WIDTH;
   localparam int unsigned SW     = AXIL_STRB_WIDTH;
   localparam int unsigned ASHIFT = $clog2(DW / 8);
   localparam int unsigned IW     = AXIL_ADDR_WIDTH - ASHIFT;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   logic [IW-1:0]    aw_idx;
   logic [IW-1:0]    ar_idx;
   logic             aw_v;
   logic             w_v;
   logic             ar_v;
   logic [DW+SW-1:0] w_payload;
   logic [DW-1:0]    w_data;
   logic [SW-1:0]    w_strb;

   logic             wr_commit_c;
   logic             rd_commit_c;
   logic             aw_in_range_c;
   logic             aw_is_rw_c;
   logic             ar_in_range_c;
   logic [NUM_REGS-1:0] wr_hit_c;
   logic [1:0]       bresp_next_c;
   logic [1:0]       rresp_next_c;
   logic [DW-1:0]    rdata_next_c;

   logic [DW-1:0]    regs     [NUM_REGS];
   logic [DW-1:0]    reg_next [NUM_REGS];

   // Low address bits select bytes within a register and carry no information here
   logic unused_inputs;
   assign unused_inputs = ^{s_axil_awaddr[ASHIFT-1:0], s_axil_araddr[ASHIFT-1:0], ro_val};

   svc_skidbuf #(.WIDTH(IW)) u_aw_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (s_axil_awvalid),
      .in_ready    (s_axil_awready),
      .in_data     (s_axil_awaddr[AXIL_ADDR_WIDTH-1:ASHIFT]),
      .out_valid_c (aw_v),
      .out_ready   (wr_commit_c),
      .out_data_c  (aw_idx)
   );

   svc_skidbuf #(.WIDTH(DW + SW)) u_w_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (s_axil_wvalid),
      .in_ready    (s_axil_wready),
      .in_data     ({s_axil_wdata, s_axil_wstrb}),
      .out_valid_c (w_v),
      .out_ready   (wr_commit_c),
      .out_data_c  (w_payload)
   );

   svc_skidbuf #(.WIDTH(IW)) u_ar_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (s_axil_arvalid),
      .in_ready    (s_axil_arready),
      .in_data     (s_axil_araddr[AXIL_ADDR_WIDTH-1:ASHIFT]),
      .out_valid_c (ar_v),
      .out_ready   (rd_commit_c),
      .out_data_c  (ar_idx)
   );

   assign w_data = w_payload[SW +: DW];
   assign w_strb = w_payload[SW-1:0];

   // Write decode and byte merge
   always_comb begin
      wr_commit_c   = aw_v && w_v && (!s_axil_bvalid || s_axil_bready);
      aw_in_range_c = 1'b0;
      aw_is_rw_c    = 1'b0;
      wr_hit_c      = '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (aw_idx == IW'(i)) begin
            aw_in_range_c = 1'b1;
            aw_is_rw_c    = REG_RW[i];
         end
      end
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         wr_hit_c[i] = wr_commit_c && REG_RW[i] && (aw_idx == IW'(i));
      end
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         reg_next[i] = regs[i];
         if (wr_hit_c[i]) begin
            for (int k = 0; k < int'(SW); k++) begin
               if (w_strb[k]) reg_next[i][k*8 +: 8] = w_data[k*8 +: 8];
            end
         end
      end
      if (!aw_in_range_c)  bresp_next_c = RESP_DECERR;
      else if (aw_is_rw_c) bresp_next_c = RESP_OKAY;
      else                 bresp_next_c = RESP_SLVERR;
   end

   // Read mux; uses reg_next so a same-edge write is what the read sees
   always_comb begin
      rd_commit_c   = ar_v && (!s_axil_rvalid || s_axil_rready);
      ar_in_range_c = 1'b0;
      rdata_next_c  = '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (ar_idx == IW'(i)) begin
            ar_in_range_c = 1'b1;
            rdata_next_c  = REG_RW[i] ? reg_next[i] : ro_val[i*DW +: DW];
         end
      end
      rresp_next_c = ar_in_range_c ? RESP_OKAY : RESP_DECERR;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs[i] <= REG_RW[i] ? RESET_VALS[i*DW +: DW] : '0;
         end
         wr_pulse      <= '0;
         s_axil_bvalid <= 1'b0;
         s_axil_bresp  <= RESP_OKAY;
         s_axil_rvalid <= 1'b0;
         s_axil_rresp  <= RESP_OKAY;
         s_axil_rdata  <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs[i] <= reg_next[i];
         end
         wr_pulse <= wr_hit_c;
         if (wr_commit_c) begin
            s_axil_bvalid <= 1'b1;
            s_axil_bresp  <= bresp_next_c;
         end else if (s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
         end
         if (rd_commit_c) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rresp  <= rresp_next_c;
            s_axil_rdata  <= rdata_next_c;
         end else if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
         end
      end
   end

   // RO slices mirror the live input
   always_comb begin
      reg_val = '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         reg_val[i*DW +: DW] = REG_RW[i] ? regs[i] : ro_val[i*DW +: DW];
      end
   end

endmodule

// File: tb/tb_axil_reg_file.sv
// Directed bench for axil_reg_file: vector table of single transactions plus
// hand-written sequences for backpressure, same-cycle read/write and mid-transaction reset.

module tb_axil_reg_file;

   localparam int unsigned NR = 8;
   localparam logic [NR-1:0]      REG_RW  = 8'hFB;
   localparam logic [NR*32-1:0]   RV      = {32'h0, 32'h0, 32'h0, 32'h0,
                                             32'h12345678, 32'h0, 32'h00000040, 32'h0};
   localparam logic [NR*32-1:0]   RO      = {32'h0, 32'h0, 32'h0, 32'h0,
                                             32'h0, 32'h0000CAFE, 32'h0, 32'h0};
   localparam logic [NR*32-1:0]   RESET_VIEW = RV | RO;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [NR*32-1:0] reg_val;
   logic [NR*32-1:0] ro_val = RO;
   logic [NR-1:0]  wr_pulse;
   logic [31:0]    s_axil_awaddr = '0;
   logic           s_axil_awvalid = 1'b0;
   logic           s_axil_awready;
   logic [31:0]    s_axil_wdata = '0;
   logic [3:0]     s_axil_wstrb = '0;
   logic           s_axil_wvalid = 1'b0;
   logic           s_axil_wready;
   logic           s_axil_bvalid;
   logic [1:0]     s_axil_bresp;
   logic           s_axil_bready = 1'b0;
   logic [31:0]    s_axil_araddr = '0;
   logic           s_axil_arvalid = 1'b0;
   logic           s_axil_arready;
   logic           s_axil_rvalid;
   logic [31:0]    s_axil_rdata;
   logic [1:0]     s_axil_rresp;
   logic           s_axil_rready = 1'b0;

   int n_vec = 0;
   int n_bad = 0;
   int b_count = 0;
   int r_count = 0;

   axil_reg_file #(
      .NUM_REGS(NR), .AXIL_ADDR_WIDTH(32), .AXIL_DATA_WIDTH(32), .AXIL_STRB_WIDTH(4),
      .REG_RW(REG_RW), .RESET_VALS(RV)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .reg_val(reg_val), .ro_val(ro_val), .wr_pulse(wr_pulse),
      .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
      .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
      .s_axil_wready(s_axil_wready),
      .s_axil_bvalid(s_axil_bvalid), .s_axil_bresp(s_axil_bresp), .s_axil_bready(s_axil_bready),
      .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
      .s_axil_rvalid(s_axil_rvalid), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
      .s_axil_rready(s_axil_rready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst_n && s_axil_bvalid && s_axil_bready) b_count++;
      if (rst_n && s_axil_rvalid && s_axil_rready) r_count++;
   end

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] exp;    // rdata for reads, target register value for writes
      logic [7:0]  pulse;
   } vec_t;

   function automatic vec_t mk(bit wr, logic [31:0] addr, logic [31:0] data, logic [3:0] strb,
                               logic [1:0] resp, logic [31:0] exp, logic [7:0] pulse);
      vec_t v;
      v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
      v.resp = resp; v.exp = exp; v.pulse = pulse;
      return v;
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output bit ok, output logic [1:0] resp,
                            output logic [7:0] pulse1, output logic [7:0] pulse2);
      int n = 0;
      @(negedge clk);
      s_axil_awaddr = addr; s_axil_awvalid = 1'b1;
      s_axil_wdata = data; s_axil_wstrb = strb; s_axil_wvalid = 1'b1;
      s_axil_bready = 1'b0;
      while (!(s_axil_awready && s_axil_wready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      ok = s_axil_bvalid; resp = s_axil_bresp; pulse1 = wr_pulse;
      s_axil_bready = 1'b1;
      @(posedge clk); #1;
      pulse2 = wr_pulse;
      s_axil_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output bit ok, output logic [1:0] resp,
                           output logic [31:0] data);
      int n = 0;
      @(negedge clk);
      s_axil_araddr = addr; s_axil_arvalid = 1'b1; s_axil_rready = 1'b0;
      while (!s_axil_arready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      s_axil_arvalid = 1'b0;
      ok = s_axil_rvalid; resp = s_axil_rresp; data = s_axil_rdata;
      s_axil_rready = 1'b1;
      @(posedge clk); #1;
      s_axil_rready = 1'b0;
   endtask

   vec_t vecs[15];

   initial begin
      bit           ok;
      logic [1:0]   resp;
      logic [31:0]  data;
      logic [7:0]   p1, p2;
      logic [255:0] snap;
      int           b0, r0, idx;

      vecs[0]  = mk(1'b0, 32'h04, 32'h0,        4'h0, 2'b00, 32'h00000040, 8'h00);
      vecs[1]  = mk(1'b0, 32'h0C, 32'h0,        4'h0, 2'b00, 32'h12345678, 8'h00);
      vecs[2]  = mk(1'b0, 32'h00, 32'h0,        4'h0, 2'b00, 32'h00000000, 8'h00);
      vecs[3]  = mk(1'b1, 32'h00, 32'hDEADBEEF, 4'hF, 2'b00, 32'hDEADBEEF, 8'h01);
      vecs[4]  = mk(1'b1, 32'h00, 32'h11223344, 4'h5, 2'b00, 32'hDE22BE44, 8'h01);
      vecs[5]  = mk(1'b0, 32'h00, 32'h0,        4'h0, 2'b00, 32'hDE22BE44, 8'h00);
      vecs[6]  = mk(1'b0, 32'h03, 32'h0,        4'h0, 2'b00, 32'hDE22BE44, 8'h00);
      vecs[7]  = mk(1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0000CAFE, 8'h00);
      vecs[8]  = mk(1'b0, 32'h08, 32'h0,        4'h0, 2'b00, 32'h0000CAFE, 8'h00);
      vecs[9]  = mk(1'b1, 32'h20, 32'h12345678, 4'hF, 2'b11, 32'h0,        8'h00);
      vecs[10] = mk(1'b0, 32'h20, 32'h0,        4'h0, 2'b11, 32'h00000000, 8'h00);
      vecs[11] = mk(1'b1, 32'h1C, 32'hA5A5A5A5, 4'h0, 2'b00, 32'h00000000, 8'h80);
      vecs[12] = mk(1'b1, 32'h1C, 32'h0000BB00, 4'h2, 2'b00, 32'h0000BB00, 8'h80);
      vecs[13] = mk(1'b0, 32'h1E, 32'h0,        4'h0, 2'b00, 32'h0000BB00, 8'h00);
      vecs[14] = mk(1'b0, 32'h7C, 32'h0,        4'h0, 2'b11, 32'h00000000, 8'h00);

      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_bvalid", 256'(s_axil_bvalid), 256'(1'b0));
      check("rst_rvalid", 256'(s_axil_rvalid), 256'(1'b0));
      check("rst_bresp", 256'(s_axil_bresp), 256'(2'b00));
      check("rst_rresp_rdata", 256'({s_axil_rresp, s_axil_rdata}), 256'(34'h0));
      check("rst_wr_pulse", 256'(wr_pulse), 256'(8'h00));
      check("rst_readies", 256'({s_axil_awready, s_axil_wready, s_axil_arready}), 256'(3'b111));
      check("rst_reg_val", 256'(reg_val), 256'(RESET_VIEW));

      for (int v = 0; v < 15; v++) begin
         idx = int'(vecs[v].addr[31:2]);
         if (vecs[v].wr) begin
            snap = 256'(reg_val);
            axi_write(vecs[v].addr, vecs[v].data, vecs[v].strb, ok, resp, p1, p2);
            check($sformatf("v%0d_bvalid", v), 256'(ok), 256'(1'b1));
            check($sformatf("v%0d_bresp", v), 256'(resp), 256'(vecs[v].resp));
            check($sformatf("v%0d_pulse", v), 256'(p1), 256'(vecs[v].pulse));
            check($sformatf("v%0d_pulse_end", v), 256'(p2), 256'(8'h00));
            if (idx < int'(NR))
               check($sformatf("v%0d_reg", v), 256'(reg_val[idx*32 +: 32]), 256'(vecs[v].exp));
            else
               check($sformatf("v%0d_regs_kept", v), 256'(reg_val), snap);
         end else begin
            axi_read(vecs[v].addr, ok, resp, data);
            check($sformatf("v%0d_rvalid", v), 256'(ok), 256'(1'b1));
            check($sformatf("v%0d_rresp", v), 256'(resp), 256'(vecs[v].resp));
            check($sformatf("v%0d_rdata", v), 256'(data), 256'(vecs[v].exp));
         end
      end

      // AW three cycles ahead of W, then a second write held behind an unaccepted B
      b0 = b_count;
      @(negedge clk);
      s_axil_bready = 1'b0;
      s_axil_awaddr = 32'h10; s_axil_awvalid = 1'b1;
      @(posedge clk); #1;
      s_axil_awvalid = 1'b0;
      check("seqA_aw_held", 256'(s_axil_awready), 256'(1'b0));
      check("seqA_no_early_b", 256'(s_axil_bvalid), 256'(1'b0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      s_axil_wdata = 32'h11110000; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
      @(posedge clk); #1;
      s_axil_wvalid = 1'b0;
      check("seqA_b1_valid", 256'({s_axil_bvalid, s_axil_bresp}), 256'(3'b100));
      check("seqA_reg4", 256'(reg_val[4*32 +: 32]), 256'(32'h11110000));
      check("seqA_pulse4", 256'(wr_pulse), 256'(8'h10));
      @(negedge clk);
      s_axil_awaddr = 32'h14; s_axil_awvalid = 1'b1;
      s_axil_wdata = 32'h00000055; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
      @(posedge clk); #1;
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      check("seqA_bufs_full", 256'({s_axil_awready, s_axil_wready}), 256'(2'b00));
      check("seqA_pulse_gone", 256'(wr_pulse), 256'(8'h00));
      repeat (3) @(posedge clk);
      #1;
      check("seqA_reg5_held", 256'(reg_val[5*32 +: 32]), 256'(32'h0));
      check("seqA_b1_held", 256'({s_axil_bvalid, s_axil_bresp}), 256'(3'b100));
      @(negedge clk); s_axil_bready = 1'b1;
      @(posedge clk); #1;
      check("seqA_b2_valid", 256'({s_axil_bvalid, s_axil_bresp}), 256'(3'b100));
      check("seqA_reg5", 256'(reg_val[5*32 +: 32]), 256'(32'h00000055));
      check("seqA_pulse5", 256'(wr_pulse), 256'(8'h20));
      check("seqA_reg4_kept", 256'(reg_val[4*32 +: 32]), 256'(32'h11110000));
      @(posedge clk); #1;
      s_axil_bready = 1'b0;
      check("seqA_b_idle", 256'(s_axil_bvalid), 256'(1'b0));
      check("seqA_b_count", 256'(b_count - b0), 256'(2));

      // Same-edge write and read of reg3: the read returns the new value
      @(negedge clk);
      s_axil_awaddr = 32'h0C; s_axil_awvalid = 1'b1;
      s_axil_wdata = 32'h0BADF00D; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
      s_axil_araddr = 32'h0C; s_axil_arvalid = 1'b1;
      @(posedge clk); #1;
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
      check("seqB_rdata", 256'({s_axil_rvalid, s_axil_rresp, s_axil_rdata}), 256'({3'b100, 32'h0BADF00D}));
      check("seqB_reg3", 256'(reg_val[3*32 +: 32]), 256'(32'h0BADF00D));
      @(negedge clk); s_axil_bready = 1'b1; s_axil_rready = 1'b1;
      @(posedge clk); #1;
      s_axil_bready = 1'b0; s_axil_rready = 1'b0;

      // Reset while a B is pending, an R is pending and a second AR sits in the buffer
      @(negedge clk);
      s_axil_awaddr = 32'h18; s_axil_awvalid = 1'b1;
      s_axil_wdata = 32'h66; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
      s_axil_araddr = 32'h00; s_axil_arvalid = 1'b1;
      @(posedge clk); #1;
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      s_axil_araddr = 32'h04;
      @(posedge clk); #1;
      s_axil_arvalid = 1'b0;
      check("seqC_pre_state", 256'({s_axil_bvalid, s_axil_rvalid, s_axil_arready}), 256'(3'b110));
      #2 rst_n = 1'b0;
      #1;
      check("seqC_rst_valids", 256'({s_axil_bvalid, s_axil_rvalid}), 256'(2'b00));
      check("seqC_rst_regs", 256'(reg_val), 256'(RESET_VIEW));
      check("seqC_rst_arready", 256'(s_axil_arready), 256'(1'b1));
      @(negedge clk);
      rst_n = 1'b1; s_axil_bready = 1'b1; s_axil_rready = 1'b1;
      b0 = b_count; r0 = r_count;
      repeat (5) @(posedge clk);
      #1;
      check("seqC_no_stale", 256'({s_axil_bvalid, s_axil_rvalid}), 256'(2'b00));
      check("seqC_no_handshakes", 256'((b_count - b0) + (r_count - r0)), 256'(0));
      check("seqC_regs_after", 256'(reg_val), 256'(RESET_VIEW));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
